scanline_buffer: RTL and testbench



---
 rtl/ppu_pkg.sv | 24 ++
 rtl/scanline_bank_mem.sv | 27 ++
 rtl/scanline_buffer.sv | 183 ++++++++++++++++++
 tb/tb_scanline_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types and constants for the scanline buffer: read-FSM states,
// line geometry defaults and the pixel-lane extraction helper.
package ppu_pkg;

  localparam int PIX_W_DEFAULT           = 8;
  localparam int GROUPS_PER_LINE_DEFAULT = 32;
  localparam int LINE_PIXELS             = 256;
  localparam int GROUP_W                 = 64;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_DRAIN = 2'd1,
    RD_BLANK = 2'd2
  } rd_state_e;

  // Leftmost pixel of a group lives in the top byte, so position 0 maps to lane 7.
  function automatic logic [7:0] group_pixel(input logic [GROUP_W-1:0] group,
                                             input logic [2:0] pos);
    logic [2:0] lane;
    lane = 3'd7 - pos;
    return group[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/scanline_bank_mem.sv
// Two-bank group storage: 2 x 32 x 64-bit array, one synchronous write port
// and one asynchronous read port.
module scanline_bank_mem
  import ppu_pkg::*;
(
  input  logic               clk,
  input  logic               wr_en,
  input  logic               wr_bank,
  input  logic [4:0]         wr_idx,
  input  logic [GROUP_W-1:0] wr_data,
  input  logic               rd_bank,
  input  logic [4:0]         rd_idx,
  output logic [GROUP_W-1:0] rd_data
);

  logic [GROUP_W-1:0] mem [2][32];

  // Storage is not reset; validity is tracked by the full flags in the top.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/scanline_buffer.sv
// Ping-pong scanline buffer: fills one bank of pixel groups while the other
// drains one pixel per accepted cycle. Optional macro: SCANLINE_LEFT_CLIP_EN.
module scanline_buffer
  import ppu_pkg::*;
#(
  parameter int GROUPS_PER_LINE = GROUPS_PER_LINE_DEFAULT,
  parameter int PIX_W           = PIX_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               grp_valid,
  output logic               grp_ready,
  input  logic [GROUP_W-1:0] grp_data,
  input  logic               line_start,
  input  logic [PIX_W-1:0]   backdrop,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic [7:0]         pix_x,
  output logic               pix_last,
  output logic               underrun,
  output logic               overrun,
  input  logic               err_clr
`ifdef SCANLINE_LEFT_CLIP_EN
  ,
  input  logic               clip_left
`endif
);

  localparam logic [4:0] LAST_IDX = 5'(GROUPS_PER_LINE - 1);
  localparam logic [7:0] LAST_X   = 8'(GROUPS_PER_LINE * 8 - 1);

  rd_state_e          state, state_nxt;
  logic [7:0]         x, x_nxt;
  logic [1:0]         full, full_nxt;
  logic               wr_bank, rd_bank;
  logic [4:0]         wr_idx;
  logic               wr_fire, wr_done, rd_done;
  logic               ur_set, ov_set;
  logic               clip_active;
  logic [GROUP_W-1:0] rd_data;

  assign grp_ready = ~full[wr_bank];
  assign wr_fire   = grp_valid & grp_ready;
  assign wr_done   = wr_fire & (wr_idx == LAST_IDX);
  assign rd_done   = (state == RD_DRAIN) & pix_ready & (x == LAST_X);

  scanline_bank_mem u_mem (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_bank (wr_bank),
    .wr_idx  (wr_idx),
    .wr_data (grp_data),
    .rd_bank (rd_bank),
    .rd_idx  (x[7:3]),
    .rd_data (rd_data)
  );

  // Fill and drain touch different banks, so set and clear never collide.
  always_comb begin
    full_nxt    = full;
    full_nxt[0] = (full[0] | (wr_done & ~wr_bank)) & ~(rd_done & ~rd_bank);
    full_nxt[1] = (full[1] | (wr_done &  wr_bank)) & ~(rd_done &  rd_bank);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= 5'd0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_done) begin
        wr_idx  <= 5'd0;
        wr_bank <= ~wr_bank;
      end else if (wr_fire) begin
        wr_idx  <= wr_idx + 5'd1;
      end
    end
  end

  // Only the registered full flag is consulted, so a bank finishing on the
  // same cycle as line_start still reads as empty.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    ur_set    = 1'b0;
    ov_set    = 1'b0;
    case (state)
      RD_IDLE: begin
        if (line_start) begin
          x_nxt = 8'd0;
          if (full[rd_bank]) begin
            state_nxt = RD_DRAIN;
          end else begin
            state_nxt = RD_BLANK;
            ur_set    = 1'b1;
          end
        end else begin
          state_nxt = RD_IDLE;
        end
      end
      RD_DRAIN, RD_BLANK: begin
        ov_set = line_start;
        if (pix_ready) begin
          if (x == LAST_X) begin
            x_nxt     = 8'd0;
            state_nxt = RD_IDLE;
          end else begin
            x_nxt = x + 8'd1;
          end
        end else begin
          x_nxt = x;
        end
      end
      default: begin
        state_nxt = RD_IDLE;
        x_nxt     = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RD_IDLE;
      x       <= 8'd0;
      rd_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      if (rd_done) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // Clearing wins over a set arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      underrun <= underrun | ur_set;
      overrun  <= overrun | ov_set;
    end
  end

`ifdef SCANLINE_LEFT_CLIP_EN
  logic clip;

  always_ff @(posedge clk) begin
    if (rst) begin
      clip <= 1'b0;
    end else if ((state == RD_IDLE) && line_start) begin
      clip <= clip_left;
    end
  end

  assign clip_active = clip & (x < 8'd8);
`else
  assign clip_active = 1'b0;
`endif

  assign pix_valid = (state != RD_IDLE);
  assign pix_x     = x;
  assign pix_last  = pix_valid & (x == LAST_X);

  always_comb begin
    pix_data = {PIX_W{1'b0}};
    case (state)
      RD_DRAIN: begin
        if (clip_active) begin
          pix_data = backdrop;
        end else begin
          pix_data = PIX_W'(group_pixel(rd_data, x[2:0]));
        end
      end
      RD_BLANK: pix_data = backdrop;
      default:  pix_data = {PIX_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_scanline_buffer.sv
// Self-checking bench for scanline_buffer: table-driven line scenarios plus
// hand-written corner sequences, pixels checked against a scoreboard queue.
module tb_scanline_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        grp_valid;
  logic        grp_ready;
  logic [63:0] grp_data;
  logic        line_start;
  logic [7:0]  backdrop;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic [7:0]  pix_x;
  logic        pix_last;
  logic        underrun;
  logic        overrun;
  logic        err_clr;

  always #5 clk = ~clk;

  scanline_buffer dut (
    .clk(clk), .rst(rst),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_data(grp_data),
    .line_start(line_start), .backdrop(backdrop),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_last(pix_last),
    .underrun(underrun), .overrun(overrun), .err_clr(err_clr)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] x;
    logic       last;
  } pix_t;

  typedef struct {
    int         fills;
    logic [7:0] base;
    logic [7:0] bd;
    bit         stall;
    bit         exp_ur;
    int         exp_cyc;
  } vec_t;

  pix_t       sbq[$];
  logic [7:0] fill_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       obs_valid;
  logic       obs_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample and score at the falling edge, return 1 ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    obs_valid = pix_valid;
    obs_ready = grp_ready;
    if (pix_valid && !rst) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_pixel: x=%0d data=%0h with nothing expected", pix_x, pix_data);
      end else begin
        chk("pixel{data,x,last}", {15'd0, pix_data, pix_x, pix_last},
            {15'd0, sbq[0].data, sbq[0].x, sbq[0].last});
        if (pix_ready) void'(sbq.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] gdata(input logic [7:0] base, input int k);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = base + 8'(8 * k + 7 - j);
    return d;
  endfunction

  task automatic push_line(input logic [7:0] base, input bit blank);
    for (int i = 0; i < 256; i++) begin
      pix_t p;
      p.data = blank ? backdrop : base + 8'(i);
      p.x    = 8'(i);
      p.last = (i == 255);
      sbq.push_back(p);
    end
  endtask

  task automatic write_groups(input logic [7:0] base, input int first, input int last_k);
    int guard;
    for (int k = first; k <= last_k; k++) begin
      guard     = 0;
      grp_valid = 1'b1;
      grp_data  = gdata(base, k);
      while (!grp_ready && guard < 100) begin
        tick();
        guard++;
      end
      if (!grp_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL grp_ready_timeout: group %0d never accepted", k);
      end
      tick();
    end
    grp_valid = 1'b0;
    if (last_k == 31) fill_q.push_back(base);
  endtask

  task automatic start_line();
    line_start = 1'b1;
    if (fill_q.size() > 0) push_line(fill_q.pop_front(), 1'b0);
    else push_line(8'h00, 1'b1);
    tick();
    line_start = 1'b0;
  endtask

  task automatic drain(input bit stall, input int stop_at, output int cycles);
    int n;
    n      = 0;
    cycles = 0;
    while (1) begin
      if (stop_at >= 0 && sbq.size() > 0 && sbq[0].x == 8'(stop_at)) break;
      pix_ready = stall ? n[0] : 1'b1;
      tick();
      n++;
      if (!obs_valid) break;
      cycles++;
      if (n > 2000) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: pix_valid still high after %0d cycles", n);
        break;
      end
    end
    pix_ready = 1'b1;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    vec_t vt[4];
    int   cyc;

    vt[0] = '{1, 8'h00, 8'h0F, 1'b0, 1'b0, 256};
    vt[1] = '{0, 8'h00, 8'h0F, 1'b0, 1'b1, 256};
    vt[2] = '{1, 8'h40, 8'h0F, 1'b1, 1'b0, 512};
    vt[3] = '{0, 8'h00, 8'hC3, 1'b1, 1'b1, 512};

    rst = 1'b1; grp_valid = 1'b0; grp_data = 64'd0; line_start = 1'b0;
    backdrop = 8'h0F; pix_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_pix_valid", 32'(pix_valid), 32'd0);
    chk("reset_grp_ready", 32'(grp_ready), 32'd1);
    chk("reset_pix_x", 32'(pix_x), 32'd0);
    chk("reset_pix_last", 32'(pix_last), 32'd0);
    chk("reset_flags", 32'({underrun, overrun}), 32'd0);

    for (int i = 0; i < 4; i++) begin
      backdrop = vt[i].bd;
      for (int f = 0; f < vt[i].fills; f++) write_groups(vt[i].base, 0, 31);
      start_line();
      drain(vt[i].stall, -1, cyc);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].exp_cyc));
      chk($sformatf("vec%0d_queue_empty", i), 32'(sbq.size()), 32'd0);
      chk($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vt[i].exp_ur));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
      clear_errors();
      chk($sformatf("vec%0d_flags_cleared", i), 32'({underrun, overrun}), 32'd0);
    end

    // Both banks full: writer must stall until a line drains.
    write_groups(8'h10, 0, 31);
    write_groups(8'h20, 0, 31);
    chk("grp_ready_full", 32'(grp_ready), 32'd0);
    grp_valid = 1'b1;
    grp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) tick();
    chk("grp_ready_still_full", 32'(grp_ready), 32'd0);
    grp_valid = 1'b0;
    start_line();
    drain(1'b0, -1, cyc);
    chk("grp_ready_return", 32'(obs_ready), 32'd1);
    start_line();
    drain(1'b0, -1, cyc);
    chk("full_pair_queue_empty", 32'(sbq.size()), 32'd0);

    // line_start mid-line flags overrun and leaves the stream untouched.
    write_groups(8'h33, 0, 31);
    start_line();
    drain(1'b0, 100, cyc);
    line_start = 1'b1;
    pix_ready  = 1'b1;
    tick();
    line_start = 1'b0;
    drain(1'b0, -1, cyc);
    chk("overrun_queue_empty", 32'(sbq.size()), 32'd0);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_no_underrun", 32'(underrun), 32'd0);
    clear_errors();
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Bank completing on the line_start cycle still counts as empty.
    backdrop  = 8'h5A;
    write_groups(8'h50, 0, 30);
    grp_valid  = 1'b1;
    grp_data   = gdata(8'h50, 31);
    line_start = 1'b1;
    push_line(8'h00, 1'b1);
    tick();
    grp_valid  = 1'b0;
    line_start = 1'b0;
    fill_q.push_back(8'h50);
    drain(1'b0, -1, cyc);
    chk("same_cycle_underrun", 32'(underrun), 32'd1);
    clear_errors();
    start_line();
    drain(1'b0, -1, cyc);
    chk("same_cycle_late_line", 32'(sbq.size()), 32'd0);
    chk("same_cycle_no_underrun", 32'(underrun), 32'd0);

    // Reset mid-line discards everything stored.
    write_groups(8'h77, 0, 31);
    write_groups(8'h88, 0, 31);
    start_line();
    drain(1'b0, 40, cyc);
    pix_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    pix_ready = 1'b1;
    sbq.delete();
    fill_q.delete();
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_grp_ready", 32'(grp_ready), 32'd1);
    chk("rst_pix_x", 32'(pix_x), 32'd0);
    backdrop = 8'h0F;
    start_line();
    drain(1'b0, -1, cyc);
    chk("rst_blank_cycles", 32'(cyc), 32'd256);
    chk("rst_underrun", 32'(underrun), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
